cache_cmd_issue_queue: RTL

Parametrised successor to the single-entry cache-side command sender. It sits between the cache BFM and the memory controller's cache-transaction port. It buffers up to DEPTH read/write commands and issues them one at a time with a valid/ack handshake. It captures the controller-assigned tag per issued command and tracks outstanding transactions against a configurable limit.

---
 rtl/cache_cmd_issue_queue.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cache_cmd_issue_queue.sv
// cache_cmd_issue_queue
//   Buffers up to DEPTH cache read/write commands in a circular FIFO and issues
//   them in push order to the memory controller, one at a time. Each command is
//   held on the controller port until it is acknowledged. The block records the
//   controller tag for each accepted command. It also counts outstanding
//   transactions against MAX_OUT.
//
// Ports
//   i_clock, i_reset     : clock (rising edge), asynchronous active-high reset
//   i_req_*, o_req_ready : cache-side push interface (push = valid & ready)
//   i_mc_full            : controller queue full, blocks new issue
//   o_mc_*               : command presented to the controller
//   i_mc_ack, i_mc_tag   : controller accept and the tag it assigned
//   i_cmp_valid          : controller completed one outstanding command
//   o_issue_done/_tag    : one-cycle pulse and captured tag after an accept
//   o_q_count            : FIFO occupancy
//   o_out_count          : issued-but-not-completed commands
//   o_cmp_err            : sticky, completion seen with nothing outstanding
module cache_cmd_issue_queue #(
    parameter int unsigned DWIDTH  = 64,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAGW    = 3,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_req_valid,
    input  logic                       i_req_rw,
    input  logic [AWIDTH-1:0]          i_req_addr,
    input  logic [DWIDTH-1:0]          i_req_data,
    output logic                       o_req_ready,
    input  logic                       i_mc_full,
    output logic                       o_mc_valid,
    output logic                       o_mc_rw,
    output logic [AWIDTH-1:0]          o_mc_addr,
    output logic [DWIDTH-1:0]          o_mc_data,
    input  logic                       i_mc_ack,
    input  logic [TAGW-1:0]            i_mc_tag,
    input  logic                       i_cmp_valid,
    output logic                       o_issue_done,
    output logic [TAGW-1:0]            o_issue_tag,
    output logic [$clog2(DEPTH):0]     o_q_count,
    output logic [$clog2(MAX_OUT):0]   o_out_count,
    output logic                       o_cmp_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OUT_W = $clog2(MAX_OUT) + 1;
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_CNT   = OUT_W'(MAX_OUT);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e r_state;
    state_e w_state_nxt;

    // FIFO storage and pointers; pointers wrap naturally since DEPTH is 2**n
    logic              r_mem_rw   [DEPTH];
    logic [AWIDTH-1:0] r_mem_addr [DEPTH];
    logic [DWIDTH-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_q_count;

    logic [OUT_W-1:0]  r_out_count;
    logic              r_cmp_err;
    logic              r_issue_done;
    logic [TAGW-1:0]   r_issue_tag;
    logic              r_mc_rw;
    logic [AWIDTH-1:0] r_mc_addr;
    logic [DWIDTH-1:0] r_mc_data;

    logic w_push;
    logic w_launch;
    logic w_accept;

    // Ready uses only the registered count, so a pop in the same cycle never
    // makes room for a push into a full queue.
    assign o_req_ready = (r_q_count < DEPTH_CNT);
    assign w_push      = i_req_valid & o_req_ready;
    assign w_launch    = (r_state == StIdle) && (r_q_count != '0) && !i_mc_full
                         && (r_out_count < MAX_CNT);
    assign w_accept    = (r_state == StSend) && i_mc_ack;

    // FSM: state register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_launch) w_state_nxt = StSend;
            StSend:  if (i_mc_ack) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // FIFO storage needs no reset; occupancy is tracked by the counters below
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem_rw[r_wr_ptr]   <= i_req_rw;
            r_mem_addr[r_wr_ptr] <= i_req_addr;
            r_mem_data[r_wr_ptr] <= i_req_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_q_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            // Head stays in the FIFO while presented; it is popped on accept
            if (w_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_accept})
                2'b10:   r_q_count <= r_q_count + 1'b1;
                2'b01:   r_q_count <= r_q_count - 1'b1;
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    // Command registers: loaded only on launch, so they stay stable in SEND
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_mc_rw   <= 1'b0;
            r_mc_addr <= '0;
            r_mc_data <= '0;
        end else if (w_launch) begin
            r_mc_rw   <= r_mem_rw[r_rd_ptr];
            r_mc_addr <= r_mem_addr[r_rd_ptr];
            r_mc_data <= r_mem_data[r_rd_ptr];
        end
    end

    // Accept reporting and outstanding-transaction tracking
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_issue_done <= 1'b0;
            r_issue_tag  <= '0;
            r_out_count  <= '0;
            r_cmp_err    <= 1'b0;
        end else begin
            r_issue_done <= w_accept;
            if (w_accept) begin
                r_issue_tag <= i_mc_tag;
            end
            case ({w_accept, i_cmp_valid})
                2'b10: r_out_count <= r_out_count + 1'b1;
                2'b01: begin
                    if (r_out_count == '0) begin
                        r_cmp_err <= 1'b1;
                    end else begin
                        r_out_count <= r_out_count - 1'b1;
                    end
                end
                default: r_out_count <= r_out_count;
            endcase
        end
    end

    // mc_valid comes straight from the state register so reset drops it at once
    assign o_mc_valid   = (r_state == StSend);
    assign o_mc_rw      = r_mc_rw;
    assign o_mc_addr    = r_mc_addr;
    assign o_mc_data    = r_mc_data;
    assign o_issue_done = r_issue_done;
    assign o_issue_tag  = r_issue_tag;
    assign o_q_count    = r_q_count;
    assign o_out_count  = r_out_count;
    assign o_cmp_err    = r_cmp_err;

endmodule
